// File: rtl/ahf_dmem_responder.sv
// Data-memory responder: word RAM with programmable wait states and a one-entry read buffer.
// Optional macro AHF_DMEM_RDBUF_EN enables the zero-stall read buffer; without it every non-io read stalls.
module ahf_dmem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_LOG2  = 10
) (
    input  logic        Clk_pin0,
    input  logic        Reset_pin,
    input  logic [13:0] MAeff,
    input  logic [13:0] DM_in,
    input  logic        WR_DM,
    output logic [13:0] DM_out,
    output logic        ramstall,
    output logic        rd_hit
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_badWaitCycles
        $error("ahf_dmem_responder: WAIT_CYCLES must be in 1..15");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] LP_CNT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [13:0] r_mem [0:(2**DEPTH_LOG2)-1];

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [13:0] r_reqAddr;
    logic [13:0] r_reqData;
    logic        r_reqWr;
    logic        r_bufValid;
    logic [13:0] r_bufAddr;
    logic [13:0] r_bufData;

    logic                  w_io;
    logic                  w_bufMatch;
    logic                  w_needAccess;
    logic                  w_hit;
    logic                  w_commit;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [13:0]           w_accData;

    // The core decodes 0x3F00-0x3FFF itself, so those addresses never touch the array.
    assign w_io         = (MAeff[13:8] == 6'h3F);
    assign w_bufMatch   = r_bufValid && (r_bufAddr == MAeff);
    assign w_needAccess = !w_io && (WR_DM || !w_bufMatch);
    assign w_hit        = (r_state == S_IDLE) && !w_io && !WR_DM && w_bufMatch;
    assign w_commit     = (r_state == S_BUSY) && (r_cnt == 4'd0);
    assign w_idx        = r_reqAddr[DEPTH_LOG2-1:0];
    assign w_accData    = r_reqWr ? r_reqData : r_mem[w_idx];

    assign ramstall = ((r_state == S_IDLE) && w_needAccess) || (r_state == S_BUSY);

`ifdef AHF_DMEM_RDBUF_EN
    assign rd_hit = w_hit;
`else
    assign rd_hit = 1'b0;
`endif

    // Array is never cleared; a reset on the commit edge suppresses the pending write.
    always_ff @(posedge Clk_pin0) begin
        if (!Reset_pin && w_commit && r_reqWr) begin
            r_mem[w_idx] <= r_reqData;
        end
    end

    always_ff @(posedge Clk_pin0) begin
        if (Reset_pin) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_reqAddr  <= 14'd0;
            r_reqData  <= 14'd0;
            r_reqWr    <= 1'b0;
            r_bufValid <= 1'b0;
            r_bufAddr  <= 14'd0;
            r_bufData  <= 14'd0;
            DM_out     <= 14'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_needAccess) begin
                        r_reqAddr <= MAeff;
                        r_reqData <= DM_in;
                        r_reqWr   <= WR_DM;
                        r_cnt     <= LP_CNT_LOAD;
                        r_state   <= S_BUSY;
                    end else if (w_hit) begin
                        DM_out <= r_bufData;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        DM_out    <= w_accData;
                        r_bufAddr <= r_reqAddr;
                        r_bufData <= w_accData;
`ifdef AHF_DMEM_RDBUF_EN
                        r_bufValid <= 1'b1;
`else
                        r_bufValid <= 1'b0;
`endif
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahf_dmem_responder.sv
// Directed self-checking bench for ahf_dmem_responder (WAIT_CYCLES=2).
// Expectations follow AHF_DMEM_RDBUF_EN: read hits are zero-stall only when the macro is defined.
module tb_ahf_dmem_responder;

    localparam int MISS_STALL = 3;
`ifdef AHF_DMEM_RDBUF_EN
    localparam int   HIT_STALL = 0;
    localparam logic HIT_FLAG  = 1'b1;
`else
    localparam int   HIT_STALL = 3;
    localparam logic HIT_FLAG  = 1'b0;
`endif

    logic        Clk_pin0;
    logic        Reset_pin;
    logic [13:0] MAeff;
    logic [13:0] DM_in;
    logic        WR_DM;
    logic [13:0] DM_out;
    logic        ramstall;
    logic        rd_hit;

    int assertCount;
    int failCount;
    int stalls;
    logic hit;

    ahf_dmem_responder #(.WAIT_CYCLES(2), .DEPTH_LOG2(10)) dut (
        .Clk_pin0 (Clk_pin0),
        .Reset_pin(Reset_pin),
        .MAeff    (MAeff),
        .DM_in    (DM_in),
        .WR_DM    (WR_DM),
        .DM_out   (DM_out),
        .ramstall (ramstall),
        .rd_hit   (rd_hit)
    );

    initial Clk_pin0 = 1'b0;
    always #5 Clk_pin0 = ~Clk_pin0;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Holds one access on the bus until the core would advance (first cycle with ramstall low).
    task automatic applyStimulus(input logic [13:0] addr, input logic [13:0] data, input logic wr,
                                 output int nStall, output logic sawHit);
        int  cyc;
        bit  done;
        MAeff  = addr;
        DM_in  = data;
        WR_DM  = wr;
        nStall = 0;
        sawHit = 1'b0;
        done   = 1'b0;
        cyc    = 0;
        while (!done && cyc < 40) begin
            @(negedge Clk_pin0);
            if (ramstall) nStall++;
            else done = 1'b1;
            if (rd_hit) sawHit = 1'b1;
            @(posedge Clk_pin0);
            #1;
            cyc++;
        end
        if (!done) checkOutput("access_timeout", 16'(done), 16'd1);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        Reset_pin   = 1'b1;
        MAeff       = 14'h3F05;
        DM_in       = 14'h0000;
        WR_DM       = 1'b0;
        repeat (2) @(posedge Clk_pin0);
        #1;
        Reset_pin = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge Clk_pin0);
            checkOutput("reset_ramstall", 16'(ramstall), 16'd0);
            checkOutput("reset_dmout", 16'(DM_out), 16'h0000);
            checkOutput("reset_rdhit", 16'(rd_hit), 16'd0);
        end
        @(posedge Clk_pin0);
        #1;

        applyStimulus(14'h3F10, 14'h1234, 1'b1, stalls, hit);
        checkOutput("io_write_stall", 16'(stalls), 16'd0);
        checkOutput("io_write_dmout", 16'(DM_out), 16'h0000);

        applyStimulus(14'h0011, 14'h0123, 1'b1, stalls, hit);
        checkOutput("preload11_stall", 16'(stalls), 16'(MISS_STALL));

        applyStimulus(14'h0010, 14'h2ABC, 1'b1, stalls, hit);
        checkOutput("write10_stall", 16'(stalls), 16'(MISS_STALL));
        checkOutput("write10_dmout", 16'(DM_out), 16'h2ABC);

        applyStimulus(14'h0010, 14'h0000, 1'b0, stalls, hit);
        checkOutput("read10_stall", 16'(stalls), 16'(HIT_STALL));
        checkOutput("read10_hit", 16'(hit), 16'(HIT_FLAG));
        checkOutput("read10_dmout", 16'(DM_out), 16'h2ABC);

        applyStimulus(14'h0011, 14'h0000, 1'b0, stalls, hit);
        checkOutput("read11_stall", 16'(stalls), 16'(MISS_STALL));
        checkOutput("read11_hit", 16'(hit), 16'd0);
        checkOutput("read11_dmout", 16'(DM_out), 16'h0123);

        applyStimulus(14'h0010, 14'h0000, 1'b0, stalls, hit);
        checkOutput("reread10_stall", 16'(stalls), 16'(MISS_STALL));
        checkOutput("reread10_dmout", 16'(DM_out), 16'h2ABC);

        applyStimulus(14'h0020, 14'h1111, 1'b1, stalls, hit);
        checkOutput("b2b_first_stall", 16'(stalls), 16'(MISS_STALL));
        applyStimulus(14'h0021, 14'h2222, 1'b1, stalls, hit);
        checkOutput("b2b_second_stall", 16'(stalls), 16'(MISS_STALL));

        applyStimulus(14'h0020, 14'h0000, 1'b0, stalls, hit);
        checkOutput("read20_dmout", 16'(DM_out), 16'h1111);
        checkOutput("read20_stall", 16'(stalls), 16'(MISS_STALL));
        applyStimulus(14'h0021, 14'h0000, 1'b0, stalls, hit);
        checkOutput("read21_dmout", 16'(DM_out), 16'h2222);

        // A store to the buffered address must stall and refresh the buffer.
        applyStimulus(14'h0021, 14'h0333, 1'b1, stalls, hit);
        checkOutput("write_match_stall", 16'(stalls), 16'(MISS_STALL));
        checkOutput("write_match_hit", 16'(hit), 16'd0);
        applyStimulus(14'h0021, 14'h0000, 1'b0, stalls, hit);
        checkOutput("read21_updated_dmout", 16'(DM_out), 16'h0333);
        checkOutput("read21_updated_stall", 16'(stalls), 16'(HIT_STALL));

        applyStimulus(14'h0410, 14'h0000, 1'b0, stalls, hit);
        checkOutput("alias410_dmout", 16'(DM_out), 16'h2ABC);
        checkOutput("alias410_stall", 16'(stalls), 16'(MISS_STALL));

        applyStimulus(14'h0030, 14'h0005, 1'b1, stalls, hit);
        checkOutput("preload30_stall", 16'(stalls), 16'(MISS_STALL));

        // Reset lands on the edge that would have committed the write.
        MAeff = 14'h0030;
        DM_in = 14'h3FFF;
        WR_DM = 1'b1;
        @(negedge Clk_pin0);
        checkOutput("midwrite_start_stall", 16'(ramstall), 16'd1);
        @(posedge Clk_pin0);
        #1;
        @(posedge Clk_pin0);
        #1;
        Reset_pin = 1'b1;
        MAeff     = 14'h3F00;
        WR_DM     = 1'b0;
        @(negedge Clk_pin0);
        checkOutput("midwrite_busy_stall", 16'(ramstall), 16'd1);
        @(posedge Clk_pin0);
        #1;
        Reset_pin = 1'b0;
        @(negedge Clk_pin0);
        checkOutput("post_reset_stall", 16'(ramstall), 16'd0);
        checkOutput("post_reset_dmout", 16'(DM_out), 16'h0000);
        @(posedge Clk_pin0);
        #1;

        applyStimulus(14'h0030, 14'h0000, 1'b0, stalls, hit);
        checkOutput("read30_after_reset_stall", 16'(stalls), 16'(MISS_STALL));
        checkOutput("read30_after_reset_hit", 16'(hit), 16'd0);
        checkOutput("read30_after_reset_dmout", 16'(DM_out), 16'h0005);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ahf_dmem_responder.md
Name: ahf_dmem_responder

Overview:
- Data-memory responder: the memory-side end of the CPU data-memory interface (effective address, write data, write enable, read data, stall).
- Holds a 14-bit-word RAM array. Inserts programmable wait states by raising `ramstall` and keeps a one-entry read buffer so repeated reads of the same address complete without stalling.
- Sits between the CPU core's data port and the on-chip RAM.
- Passes the 0x3F00–0x3FFF I/O window through with zero wait, because the core decodes that window itself.

Parameters:
- WAIT_CYCLES, 2, BUSY-state cycles per array access (legal 1..15).
- DEPTH_LOG2, 10, log2 of array depth in words (1k words).

Ports:
- Clk_pin0  in  1  clock; all state changes on the rising edge.
- Reset_pin  in  1  reset, synchronous, active-high.
- MAeff  in  14  effective word address from the core.
- DM_in  in  14  write data.
- WR_DM  in  1  write request; 0 means read.
- DM_out  out  14  read data (registered).
- ramstall  out  1  core must freeze while this is 1.
- rd_hit  out  1  current cycle is served from the read buffer (combinational, debug).

Behaviour:
- Reset: takes effect on the rising edge with Reset_pin=1. Values after reset:
  - state=IDLE, DM_out=0, ramstall=0, rd_hit=0.
  - buffer valid=0, buffer addr/data=0, wait counter=0.
  - Array contents are not cleared.
- Reset mid-access: the access is abandoned. A pending write is NOT committed. State returns to IDLE.
- Address decode:
  - io = (MAeff[13:8]==6'h3F).
  - Array index = MAeff[DEPTH_LOG2-1:0]; higher non-io addresses alias onto the array.
- io access, any WR_DM: no stall, no array write, DM_out unchanged. The core muxes its own I/O data.
- States: IDLE, BUSY, DONE.
- IDLE, need_access = !io && (WR_DM || !(buf_valid && buf_addr==MAeff)).
  - ramstall = need_access (combinational, same cycle, so the core freezes on this edge).
  - If need_access at the edge: latch addr, wdata and wr into a request register, load counter=WAIT_CYCLES-1, go to BUSY.
  - Read hit (!io, !WR_DM, buffer match): rd_hit=1, DM_out<=buf_data, stay in IDLE.
  - WR_DM=1 and a buffer match at the same time: the write wins and there is no hit.
- BUSY: ramstall=1. Core inputs are ignored; the latched request is used.
  - Counter decrements each edge.
  - On the edge where counter==0:
    - Write: array[idx]<=wdata, DM_out<=wdata.
    - Read: DM_out<=array[idx].
    - Either way: buf_addr<=addr, buf_data<=that value, buf_valid<=1. Go to DONE.
- DONE: ramstall=0 for exactly one cycle so the core advances. No new access is accepted. Next edge goes to IDLE.
  - A WR_DM still high in the following IDLE is a new store and is serviced again.
- Total stall per miss or write = WAIT_CYCLES+1 cycles. Read latency from address to DM_out valid = WAIT_CYCLES+1 edges.
- A write to the buffered address updates the buffer, so the buffer is never stale.
- Widths: all data paths are 14 bits. The counter is 4 bits. WAIT_CYCLES outside 1..15 is a synthesis error.

Optional Feature:
- Macro: AHF_DMEM_RDBUF_EN.
- Defined: read buffer active as described; read hits take 0 stall.
- Undefined:
  - buf_valid is held at 0 and rd_hit is tied to 0.
  - Every non-io read takes the full IDLE→BUSY→DONE path with WAIT_CYCLES+1 stall cycles.
  - Writes are unchanged.

Test Plan:
- Reset check: assert Reset_pin 2 cycles, then MAeff=0x3F05, WR_DM=0 → ramstall=0 every cycle, DM_out=0, state IDLE.
- Store/load round trip: WAIT_CYCLES=2.
  - Write 0x2ABC to 0x0010 → ramstall high exactly 3 cycles, then DONE.
  - Read 0x0010 → DM_out=0x2ABC with 0 stall cycles, rd_hit=1.
- Read miss after hit: read 0x0011 (preloaded 0x0123) → 3 stall cycles, DM_out=0x0123. A re-read of 0x0010 now misses (buffer replaced) and returns 0x2ABC after 3 stall cycles.
- Back-to-back stores: WR_DM held at 1 with 0x0020→0x1111 then 0x0021→0x2222 across the DONE cycle → two separate 3-cycle stalls, each separated by one ramstall=0 cycle; both words present in the array.
- Reset mid-write: start a write of 0x3FFF to 0x0030 (preloaded 0x0005); assert reset during BUSY → array[0x30] still 0x0005, buffer invalid, ramstall=0 the next cycle.
- Macro off: build without AHF_DMEM_RDBUF_EN; read 0x0010 twice → both reads stall 3 cycles; rd_hit never 1.
